// File: rtl/hfrv_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hfrv_uart_pkg
//  Description : Shared types and register map for the HF-RISC-V UART blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package hfrv_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_e;

    localparam logic UART_REG_DATA   = 1'b0;
    localparam logic UART_REG_STATUS = 1'b1;

    localparam int ST_NEMPTY  = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_FERR    = 3;
    localparam int ST_CNT_LSB = 4;

endpackage
`default_nettype wire

// File: rtl/hfrv_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hfrv_sync_fifo
//  Description : Single-clock pointer/count FIFO; a pop of a full FIFO frees
//                room for a push in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module hfrv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full_cnt = DEPTH[c_aw:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_cnt);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hfrv_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hfrv_uart_rx
//  Description : Memory-mapped 8N1 UART receiver with RX FIFO, status register
//                and level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module hfrv_uart_rx
    import hfrv_uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxd,
    input  logic        rd_en,
    input  logic        rd_addr,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam int               c_cw       = $clog2(CLK_DIV);
    localparam int               c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [c_cw-1:0]  c_cnt_half = c_cw'(CLK_DIV / 2 - 1);
    localparam logic [c_cw-1:0]  c_cnt_full = c_cw'(CLK_DIV - 1);

    logic            r_sync1;
    logic            r_sync2;
    uart_rx_state_e  r_state;
    uart_rx_state_e  w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_ovr;
    logic            r_ferr;

    logic            w_rx;
    logic            w_tick;
    logic            w_push;
    logic            w_ferr_set;
    logic            w_ovr_set;
    logic            w_data_rd;
    logic            w_status_rd;
    logic [7:0]      w_fifo_rdata;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_aw:0]   w_fifo_count;
    logic [31:0]     w_status_word;
    logic [31:0]     w_data_word;

    assign w_rx        = r_sync2;
    assign w_tick      = (r_cnt == '0);
    assign w_data_rd   = rd_en && (rd_addr == UART_REG_DATA);
    assign w_status_rd = rd_en && (rd_addr == UART_REG_STATUS);
    // A full FIFO is never empty, so a DATA read in the push cycle always frees a slot.
    assign w_ovr_set   = w_push && w_fifo_full && !w_data_rd;
    assign irq         = !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1   <= rxd;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_push        = 1'b0;
        w_ferr_set    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = c_cnt_half;
                end
            end
            RX_START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (!w_rx) begin
                    w_state_nxt   = RX_DATA;
                    w_bit_idx_nxt = '0;
                    w_cnt_nxt     = c_cnt_full;
                end else begin
                    w_state_nxt = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_shift_nxt   = {w_rx, r_shift[7:1]};
                    w_cnt_nxt     = c_cnt_full;
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                // Leaving at mid-stop lets a following start bit be caught at once.
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = RX_IDLE;
                    w_push      = w_rx;
                    w_ferr_set  = !w_rx;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    hfrv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (r_shift),
        .i_pop   (w_data_rd),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_status_word                          = '0;
        w_status_word[ST_NEMPTY]               = !w_fifo_empty;
        w_status_word[ST_FULL]                 = w_fifo_full;
        w_status_word[ST_OVR]                  = r_ovr;
        w_status_word[ST_FERR]                 = r_ferr;
        w_status_word[ST_CNT_LSB +: c_aw + 1]  = w_fifo_count;
        w_data_word = w_fifo_empty ? 32'h0 : {24'h0, w_fifo_rdata};
    end

    // Sticky flags: a set in the same cycle as a STATUS read survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_data <= (rd_addr == UART_REG_DATA) ? w_data_word : w_status_word;
            end
            r_ovr  <= w_ovr_set  || (r_ovr  && !w_status_rd);
            r_ferr <= w_ferr_set || (r_ferr && !w_status_rd);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hfrv_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hfrv_uart_rx
//  Description : Directed bench for hfrv_uart_rx with a frame-level reference
//                model compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hfrv_uart_rx;

    localparam int D     = 16;
    localparam int H     = D / 2;
    localparam int DEPTH = 4;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        rxd     = 1'b1;
    logic        rd_en   = 1'b0;
    logic        rd_addr = 1'b0;
    logic [31:0] rd_data;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hfrv_uart_rx #(
        .CLK_DIV    (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rxd     (rxd),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .irq     (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decodes the line at the nominal sample instants and
    // tracks the queue, sticky flags and read port one clock edge at a time.
    logic [7:0]  m_q [$];
    bit          m_ovr, m_ferr, m_valid, m_busy, m_ev, m_ev_ok, m_fire, m_pop, m_full_before;
    int          m_off, m_ev_dly;
    logic [7:0]  m_bits, m_ev_byte;
    logic [31:0] m_rd;

    function automatic logic [31:0] m_status();
        int n = m_q.size();
        return 32'(n * 16 + (m_ferr ? 8 : 0) + (m_ovr ? 4 : 0) +
                   (n == DEPTH ? 2 : 0) + (n != 0 ? 1 : 0));
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_rd_data", rd_data, m_rd);
            chk("cyc_irq", {31'h0, irq}, {31'h0, m_q.size() != 0});
        end
        if (reset) begin
            m_valid = 1'b1;
            m_q.delete();
            m_ovr = 0; m_ferr = 0; m_busy = 0; m_ev = 0; m_rd = '0;
        end else begin
            m_fire = 0;
            if (m_ev) begin
                m_ev_dly--;
                if (m_ev_dly == 0) begin m_fire = 1; m_ev = 0; end
            end
            m_full_before = (m_q.size() == DEPTH);
            m_pop = rd_en && !rd_addr && m_q.size() != 0;
            if (rd_en) begin
                if (!rd_addr) m_rd = (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0;
                else begin m_rd = m_status(); m_ovr = 0; m_ferr = 0; end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_fire) begin
                if (!m_ev_ok) m_ferr = 1;
                else if (m_full_before && !m_pop) m_ovr = 1;
                else m_q.push_back(m_ev_byte);
            end
            // The two-flop synchronizer delays every decision by two cycles.
            if (m_busy) begin
                m_off++;
                if (m_off == H && rxd) m_busy = 0;
                else if (m_off > H && m_off < H + 9 * D && (m_off - H) % D == 0)
                    m_bits[(m_off - H) / D - 1] = rxd;
                else if (m_off == H + 9 * D) begin
                    m_busy = 0; m_ev = 1; m_ev_dly = 2; m_ev_ok = rxd; m_ev_byte = m_bits;
                end
            end else if (!rxd) begin
                m_busy = 1; m_off = 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0; tick(D);
        for (int k = 0; k < 8; k++) begin rxd = b[k]; tick(D); end
        rxd = stop; tick(D);
        rxd = 1'b1;
    endtask

    task automatic rd(input logic a, output logic [31:0] v);
        rd_en = 1'b1; rd_addr = a; tick(1);
        rd_en = 1'b0;
        @(negedge clk); v = rd_data;
    endtask

    initial begin
        logic [31:0] v;
        int          t0, lat;
        logic [7:0]  pat;

        reset = 1'b1; tick(3);
        reset = 1'b0; tick(5);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);

        // Single frame and end-to-end latency
        t0 = cyc; lat = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 400 && lat < 0; i++) begin
                    @(negedge clk);
                    if (irq === 1'b1) lat = cyc - t0;
                end
            end
        join
        chk("irq_latency", lat, 32'd155);
        tick(4);
        rd(1'b1, v); chk("st_one_byte", v, 32'h011);
        rd(1'b0, v); chk("data_a5", v, 32'h0A5);
        chk("irq_after_pop", {31'h0, irq}, 32'h0);
        rd(1'b1, v); chk("st_after_pop", v, 32'h000);

        // Glitch shorter than half a bit
        rxd = 1'b0; tick(4); rxd = 1'b1; tick(40);
        rd(1'b1, v); chk("st_glitch", v, 32'h000);

        // Framing error, then sticky clear
        send_frame(8'h3C, 1'b0); tick(40);
        rd(1'b1, v); chk("st_ferr", v, 32'h008);
        rd(1'b1, v); chk("st_ferr_clr", v, 32'h000);

        // Overrun: five back-to-back frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        tick(20);
        rd(1'b1, v); chk("st_ovr", v, 32'h047);
        for (int i = 1; i <= 4; i++) begin rd(1'b0, v); chk("data_ovr_seq", v, 32'(i)); end
        rd(1'b0, v); chk("data_empty", v, 32'h000);

        // DATA read lands in the same cycle as the push into a full FIFO
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        fork
            send_frame(8'h05, 1'b1);
            begin
                tick(154);
                rd_en = 1'b1; rd_addr = 1'b0; tick(1);
                rd_en = 1'b0;
                @(negedge clk); v = rd_data;
            end
        join
        chk("pop_push_data", v, 32'h001);
        tick(10);
        rd(1'b1, v); chk("st_pop_push", v, 32'h043);
        rd(1'b0, v); chk("head_after", v, 32'h002);
        rd(1'b1, v); chk("st_pre_reset", v, 32'h031);

        // Reset in the middle of data bit 3
        pat = 8'h55;
        rxd = 1'b0; tick(D);
        for (int k = 0; k < 3; k++) begin rxd = pat[k]; tick(D); end
        rxd = pat[3]; tick(H);
        reset = 1'b1; rxd = 1'b1; tick(1);
        chk("mid_reset_rd_data", rd_data, 32'h0);
        chk("mid_reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0; tick(20);
        send_frame(8'h7E, 1'b1); tick(5);
        chk("irq_7e", {31'h0, irq}, 32'h1);
        rd(1'b0, v); chk("data_7e", v, 32'h07E);
        rd(1'b1, v); chk("st_final", v, 32'h000);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
